// File: rtl/norm_div_stage.sv
// Normalizes one core's signed psum lanes by (own_sum + peer_sum), scaled by 2^FRAC,
// using a single restoring divider shared across all lanes (one quotient bit per cycle).
module norm_div_stage #(
    parameter int unsigned col     = 8,
    parameter int unsigned bw_psum = 20,
    parameter int unsigned bw_sum  = 24,
    parameter int unsigned bw_out  = 8,
    parameter int unsigned FRAC    = 7
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [col*bw_psum-1:0]  in_data,
    input  logic [bw_sum-1:0]       sum_own,
    input  logic [bw_sum-1:0]       sum_peer,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [col*bw_out-1:0]   out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy
);

    localparam int unsigned DW   = bw_psum + FRAC;
    localparam int unsigned TW   = bw_sum + 1;
    localparam int unsigned RW   = TW + 1;
    localparam int unsigned LW   = (col > 1) ? $clog2(col) : 1;
    localparam int unsigned IW   = $clog2(DW);
    localparam int unsigned MAXQ = (1 << (bw_out - 1)) - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    in_ready_q, in_ready_d;
    logic                    out_valid_q, out_valid_d;
    logic                    busy_q, busy_d;
    logic [col*bw_out-1:0]   out_data_q, out_data_d;
    logic [col*bw_psum-1:0]  data_q, data_d;
    logic [TW-1:0]           total_q, total_d;
    logic [LW-1:0]           lane_q, lane_d;
    logic [IW-1:0]           iter_q, iter_d;
    logic [TW-1:0]           rem_q, rem_d;
    logic [DW-1:0]           quot_q, quot_d;

    // Datapath for the current lane / current quotient bit
    logic [bw_psum-1:0]      lane_x;
    logic                    lane_neg;
    logic [bw_psum-1:0]      lane_mag;
    logic [DW-1:0]           dividend;
    logic [TW-1:0]           rem_in;
    logic [DW-1:0]           quot_in;
    logic [RW-1:0]           rem_shift;
    logic [RW-1:0]           rem_next;
    logic                    q_bit;
    logic [DW-1:0]           quot_next;
    logic [bw_out-1:0]       q_clamped;
    logic [bw_out-1:0]       lane_res;

    always_comb begin
        lane_x    = data_q[32'(lane_q) * bw_psum +: bw_psum];
        lane_neg  = lane_x[bw_psum-1];
        lane_mag  = lane_neg ? (~lane_x + bw_psum'(1)) : lane_x;
        dividend  = {lane_mag, {FRAC{1'b0}}};

        // First iteration of each lane starts from a clean remainder/quotient
        rem_in    = (iter_q == '0) ? '0 : rem_q;
        quot_in   = (iter_q == '0) ? '0 : quot_q;
        rem_shift = {rem_in, dividend[IW'(DW - 1) - iter_q]};

        if (rem_shift >= RW'(total_q)) begin
            rem_next = rem_shift - RW'(total_q);
            q_bit    = 1'b1;
        end else begin
            rem_next = rem_shift;
            q_bit    = 1'b0;
        end
        quot_next = DW'({quot_in, q_bit});

        if ((total_q == '0) || (quot_next > DW'(MAXQ))) begin
            q_clamped = bw_out'(MAXQ);
        end else begin
            q_clamped = quot_next[bw_out-1:0];
        end

        if (lane_x == '0) begin
            lane_res = '0;
        end else if (lane_neg) begin
            lane_res = bw_out'(0) - q_clamped;
        end else begin
            lane_res = q_clamped;
        end
    end

    // Next-state and register updates
    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        data_d     = data_q;
        total_d    = total_q;
        lane_d     = lane_q;
        iter_d     = iter_q;
        rem_d      = rem_q;
        quot_d     = quot_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    total_d = TW'(sum_own) + TW'(sum_peer);
                    lane_d  = '0;
                    iter_d  = '0;
                    state_d = DIV;
                end
            end
            DIV: begin
                rem_d  = TW'(rem_next);
                quot_d = quot_next;
                if (iter_q == IW'(DW - 1)) begin
                    out_data_d[32'(lane_q) * bw_out +: bw_out] = lane_res;
                    iter_d = '0;
                    if (lane_q == LW'(col - 1)) begin
                        lane_d  = '0;
                        state_d = DONE;
                    end else begin
                        lane_d = lane_q + LW'(1);
                    end
                end else begin
                    iter_d = iter_q + IW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        busy_d      = (state_d == DIV);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            out_data_q  <= '0;
            data_q      <= '0;
            total_q     <= '0;
            lane_q      <= '0;
            iter_q      <= '0;
            rem_q       <= '0;
            quot_q      <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            out_data_q  <= out_data_d;
            data_q      <= data_d;
            total_q     <= total_d;
            lane_q      <= lane_d;
            iter_q      <= iter_d;
            rem_q       <= rem_d;
            quot_q      <= quot_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_norm_div_stage.sv
// Directed bench for norm_div_stage: a table of vectors with hand-computed lane results,
// plus sequences for backpressure, mid-operation reset and input isolation.
module tb_norm_div_stage;

    localparam int COL = 8;
    localparam int BP  = 20;
    localparam int BS  = 24;
    localparam int BO  = 8;
    localparam int FR  = 7;
    localparam int LAT = COL * (BP + FR);
    localparam int NV  = 5;

    typedef int lanes_t [COL];

    typedef struct packed {
        logic [COL*BP-1:0] data;
        logic [BS-1:0]     own;
        logic [BS-1:0]     peer;
        logic [COL*BO-1:0] exp;
    } vec_t;

    logic              clk;
    logic              reset;
    logic [COL*BP-1:0] in_data;
    logic [BS-1:0]     sum_own;
    logic [BS-1:0]     sum_peer;
    logic              in_valid;
    logic              in_ready;
    logic [COL*BO-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              busy;

    int n_vec  = 0;
    int n_miss = 0;

    vec_t vecs [NV];

    norm_div_stage #(
        .col    (COL),
        .bw_psum(BP),
        .bw_sum (BS),
        .bw_out (BO),
        .FRAC   (FR)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .sum_own  (sum_own),
        .sum_peer (sum_peer),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [COL*BP-1:0] pack_in(input lanes_t a);
        logic [COL*BP-1:0] r;
        r = '0;
        for (int k = 0; k < COL; k++) r[k*BP +: BP] = BP'(a[k]);
        return r;
    endfunction

    function automatic logic [COL*BO-1:0] pack_out(input lanes_t a);
        logic [COL*BO-1:0] r;
        r = '0;
        for (int k = 0; k < COL; k++) r[k*BO +: BO] = BO'(a[k]);
        return r;
    endfunction

    function automatic int lane_of(input logic [COL*BO-1:0] d, input int k);
        logic signed [BO-1:0] b;
        b = d[k*BO +: BO];
        return int'(b);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [COL*BO-1:0] exp);
        for (int k = 0; k < COL; k++)
            chk($sformatf("%s_lane%0d", tag, k), lane_of(out_data, k), lane_of(exp, k));
    endtask

    // Called at a negedge with the block idle; returns at the negedge after the accept edge
    task automatic send(input logic [COL*BP-1:0] d, input logic [BS-1:0] own,
                        input logic [BS-1:0] peer);
        chk("in_ready_before_accept", int'(in_ready), 1);
        in_data  = d;
        sum_own  = own;
        sum_peer = peer;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("busy_after_accept", int'(busy), 1);
    endtask

    // Counts cycles from the accept edge until out_valid, optionally scrambling inputs
    task automatic wait_done(input bit scramble, output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 1000) begin
            if (scramble) begin
                in_data = {$urandom, $urandom, $urandom, $urandom, $urandom};
                sum_own = BS'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        if (lat >= 1000) chk("timeout_waiting_out_valid", lat, LAT);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        chk("out_valid_after_handshake", int'(out_valid), 0);
        chk("in_ready_after_handshake", int'(in_ready), 1);
        out_ready = 1'b0;
    endtask

    initial begin
        int   lat;
        bit   seen;
        vec_t t1;
        vec_t t2;

        vecs[0] = '{data: pack_in('{0, 1, 64, -64, 256, -256, 128, 32}), own: 24'd100, peer: 24'd156,
                    exp: pack_out('{0, 0, 32, -32, 127, -127, 64, 16})};
        vecs[1] = '{data: pack_in('{5, -5, 0, 0, 0, 0, 0, 0}), own: 24'd0, peer: 24'd0,
                    exp: pack_out('{127, -127, 0, 0, 0, 0, 0, 0})};
        vecs[2] = '{data: pack_in('{-524288, 0, 0, 0, 0, 0, 0, 0}), own: 24'h800000, peer: 24'h800000,
                    exp: pack_out('{-4, 0, 0, 0, 0, 0, 0, 0})};
        vecs[3] = '{data: pack_in('{1000, 500, -500, 7, -8, 999, 990, -1}), own: 24'd600, peer: 24'd400,
                    exp: pack_out('{127, 64, -64, 0, -1, 127, 126, 0})};
        vecs[4] = '{data: pack_in('{524287, -524288, 0, 0, 0, 0, 0, 0}), own: 24'hFFFFFF, peer: 24'hFFFFFF,
                    exp: pack_out('{1, -2, 0, 0, 0, 0, 0, 0})};
        t1 = vecs[0];
        t2 = vecs[1];

        reset     = 1'b0;
        in_data   = '0;
        sum_own   = '0;
        sum_peer  = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_out_data_zero", int'(out_data == '0), 1);
        reset = 1'b1;
        @(negedge clk);

        // Table-driven vectors
        for (int i = 0; i < NV; i++) begin
            send(vecs[i].data, vecs[i].own, vecs[i].peer);
            wait_done(1'b0, lat);
            chk($sformatf("v%0d_latency", i), lat, LAT);
            check_out($sformatf("v%0d", i), vecs[i].exp);
            handshake();
        end

        // Backpressure: result held, new vector waits, accepted one cycle after handshake
        send(t1.data, t1.own, t1.peer);
        wait_done(1'b0, lat);
        check_out("bp_t1", t1.exp);
        in_data  = t2.data;
        sum_own  = t2.own;
        sum_peer = t2.peer;
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("bp_hold_data_c%0d", c), int'(out_data == t1.exp), 1);
            chk($sformatf("bp_in_ready_c%0d", c), int'(in_ready), 0);
            chk($sformatf("bp_out_valid_c%0d", c), int'(out_valid), 1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_release_in_ready", int'(in_ready), 1);
        chk("bp_release_out_valid", int'(out_valid), 0);
        chk("bp_release_busy", int'(busy), 0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_next_accept_busy", int'(busy), 1);
        wait_done(1'b0, lat);
        chk("bp_t2_latency", lat, LAT);
        check_out("bp_t2", t2.exp);
        handshake();

        // Mid-operation reset discards the vector in flight
        send(t1.data, t1.own, t1.peer);
        repeat (49) @(negedge clk);
        chk("rst_midop_busy", int'(busy), 1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_data_zero", int'(out_data == '0), 1);
        chk("rst_busy", int'(busy), 0);
        seen = 1'b0;
        for (int c = 0; c < LAT + 50; c++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1'b1;
        end
        chk("rst_no_output", int'(seen), 0);
        send(t1.data, t1.own, t1.peer);
        wait_done(1'b0, lat);
        chk("rst_t1_latency", lat, LAT);
        check_out("rst_t1", t1.exp);
        handshake();

        // Input isolation with out_ready held high
        out_ready = 1'b1;
        send(t1.data, t1.own, t1.peer);
        wait_done(1'b1, lat);
        chk("iso_latency", lat, LAT);
        check_out("iso_t1", t1.exp);
        in_data = '0;
        sum_own = '0;
        @(negedge clk);
        chk("iso_out_valid_drop", int'(out_valid), 0);
        chk("iso_out_data_kept", int'(out_data == t1.exp), 1);
        out_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
